powertrain_state_ctrl: RTL

//  Parametrised ignition + gear-selector controller. Successor to the inline OFF/ACC/RUN FSM
//  and gear register in the top level. Adds a CRANK phase, N-gear selection with speed

---
 rtl/powertrain_state_ctrl_pkg.sv | 21 ++
 rtl/powertrain_state_ctrl_key_edge_sampler.sv | 23 ++
 rtl/powertrain_state_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/powertrain_state_ctrl_pkg.sv
// Shared power-state codes and gear index constants for the powertrain controller.
package pwr_pkg;

  typedef enum logic [1:0] {
    PWR_OFF   = 2'd0,
    PWR_ACC   = 2'd1,
    PWR_CRANK = 2'd2,
    PWR_RUN   = 2'd3
  } pwr_state_e;

  localparam int GEAR_P  = 0;
  localparam int GEAR_R  = 1;
  localparam int GEAR_N  = 2;
  localparam int GEAR_D0 = 3;

  // P and R may only be engaged at standstill.
  function automatic logic gear_needs_stop(input int idx);
    return (idx == GEAR_P) || (idx == GEAR_R);
  endfunction

endpackage

// File: rtl/powertrain_state_ctrl_key_edge_sampler.sv
// Samples the raw ignition key on tick_i and flags a rising edge between consecutive samples.
module key_edge_sampler (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_i,
  output logic edge_o
);

  logic key_q, key_d;

  always_comb begin
    key_d = tick_i ? key_i : key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_q <= 1'b0;
    else        key_q <= key_d;
  end

  assign edge_o = tick_i & key_i & ~key_q;

endmodule

// File: rtl/powertrain_state_ctrl.sv
// Ignition FSM (OFF/ACC/CRANK/RUN) plus interlocked gear arbiter.
// Define PWR_ACC_TIMEOUT_EN to auto-return from an idle ACC to OFF.
module powertrain_state_ctrl
  import pwr_pkg::*;
#(
  parameter int NUM_GEARS         = 4,
  parameter int GEAR_W            = 2,
  parameter int SPD_W             = 8,
  parameter int FUEL_W            = 8,
  parameter int CRANK_TICKS       = 8,
  parameter int ACC_TIMEOUT_TICKS = 600
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic                 key_start,
  input  logic                 brake,
  input  logic [SPD_W-1:0]     speed,
  input  logic [FUEL_W-1:0]    fuel,
  input  logic [NUM_GEARS-1:0] gear_req,
  output logic [1:0]           power_state,
  output logic                 engine_on,
  output logic                 acc_on,
  output logic [GEAR_W-1:0]    gear_idx,
  output logic                 gear_changed,
  output logic                 gear_reject
);

  localparam int CW = $clog2(CRANK_TICKS + 1);

  pwr_state_e        state_q, state_d;
  logic [CW-1:0]     crank_q, crank_d;
  logic [GEAR_W-1:0] gear_q, gear_d, req_idx;
  logic              changed_q, changed_d, reject_q, reject_d, blocked_q, blocked_d;
  logic              key_edge, clean, found, want;

  key_edge_sampler u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_i (tick_i),
    .key_i  (key_start),
    .edge_o (key_edge)
  );

`ifdef PWR_ACC_TIMEOUT_EN
  localparam int AW = $clog2(ACC_TIMEOUT_TICKS + 1);
  logic [AW-1:0] acc_q, acc_d;
`endif

  assign clean = key_edge & brake & (gear_q == GEAR_W'(GEAR_P)) & (fuel != '0);

  always_comb begin
    state_d = state_q;
    crank_d = crank_q;
    if (tick_i) begin
      unique case (state_q)
        PWR_OFF: if (key_edge) state_d = clean ? PWR_CRANK : PWR_ACC;
        PWR_ACC: begin
`ifdef PWR_ACC_TIMEOUT_EN
          if (clean)                                                 state_d = PWR_CRANK;
          else if (key_edge && !brake)                               state_d = PWR_OFF;
          else if (!key_edge && acc_q == AW'(ACC_TIMEOUT_TICKS - 1)) state_d = PWR_OFF;
`else
          if (clean)                   state_d = PWR_CRANK;
          else if (key_edge && !brake) state_d = PWR_OFF;
`endif
        end
        // Abort is checked first so it beats completion on the same tick.
        PWR_CRANK: begin
          crank_d = crank_q + 1'b1;
          if (!brake || fuel == '0)                state_d = PWR_ACC;
          else if (crank_q == CW'(CRANK_TICKS - 1)) state_d = PWR_RUN;
        end
        PWR_RUN: begin
          if (fuel == '0)                       state_d = PWR_ACC;
          else if (key_edge && speed == '0)     state_d = PWR_OFF;
        end
        default: state_d = PWR_OFF;
      endcase
    end
    if (state_d == PWR_CRANK && state_q != PWR_CRANK) crank_d = '0;
  end

`ifdef PWR_ACC_TIMEOUT_EN
  always_comb begin
    acc_d = acc_q;
    if (state_d != PWR_ACC) acc_d = '0;
    else if (tick_i)        acc_d = key_edge ? '0 : acc_q + 1'b1;
  end
`endif

  // Lowest set request bit wins; a blocked request pulses reject only when it first appears.
  always_comb begin
    found   = 1'b0;
    req_idx = '0;
    for (int i = 0; i < NUM_GEARS; i++) begin
      if (!found && gear_req[i]) begin
        found   = 1'b1;
        req_idx = GEAR_W'(i);
      end
    end
    want      = found && (req_idx != gear_q);
    blocked_d = want && gear_needs_stop(int'(req_idx)) && (speed != '0);
    changed_d = want && !blocked_d;
    reject_d  = blocked_d && !blocked_q;
    gear_d    = changed_d ? req_idx : gear_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PWR_OFF;
      crank_q   <= '0;
      gear_q    <= GEAR_W'(GEAR_P);
      changed_q <= 1'b0;
      reject_q  <= 1'b0;
      blocked_q <= 1'b0;
`ifdef PWR_ACC_TIMEOUT_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      crank_q   <= crank_d;
      gear_q    <= gear_d;
      changed_q <= changed_d;
      reject_q  <= reject_d;
      blocked_q <= blocked_d;
`ifdef PWR_ACC_TIMEOUT_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign power_state  = state_q;
  assign engine_on    = (state_q == PWR_RUN);
  assign acc_on       = (state_q != PWR_OFF);
  assign gear_idx     = gear_q;
  assign gear_changed = changed_q;
  assign gear_reject  = reject_q;

endmodule
